// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: operand/MD hazard detection and mult/div sequencing.
// Optional stall statistics counter is built when STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [4:0] M_wa,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_div,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_E,
    output logic       md_busy,
`ifdef STALL_CNT_EN
    output logic       md_done,
    output logic [31:0] stall_count
`else
    output logic       md_done
`endif
);

    localparam int unsigned MAX_CYC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic stall;

    // Operand and MD hazard detection; tnew=0 matches go to forwarding.
    always_comb begin
        hz_rs = (D_rs != 5'd0) &&
                (((D_rs == E_wa) && (D_tuse_rs < E_tnew)) ||
                 ((D_rs == M_wa) && (D_tuse_rs < M_tnew)));
        hz_rt = (D_rt != 5'd0) &&
                (((D_rt == E_wa) && (D_tuse_rt < E_tnew)) ||
                 ((D_rt == M_wa) && (D_tuse_rt < M_tnew)));
        hz_md = D_is_md && md_busy;
        stall = hz_rs || hz_rt || hz_md;
        stall_F = stall;
        stall_D = stall;
        flush_E = stall;
    end

    // Busy covers the start cycle itself so D sees the unit as taken.
    always_comb begin
        md_busy = (state_q == BUSY) || E_md_start;
        md_done = (cnt_q == CNT_ONE);
    end

    // MD sequencer next state: load on start, count down to the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (E_md_start) begin
                    cnt_d   = E_md_div ? DIV_LOAD : MULT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // MD sequencer state register; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Stall statistics: count every stalled cycle, wrapping naturally.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Stall statistics register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios plus randomized traffic
// checked against an occupancy/hazard reference model.
module tb_pipe_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div;
    logic       stall_F, stall_D, flush_E, md_busy, md_done;
`ifdef STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int vectors = 0;
    int errors  = 0;

    // Model: number of busy cycles still owed by the MD unit,
    // counting the current cycle (0 = free).
    int md_left = 0;
    logic [31:0] m_stall_cnt = 32'd0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .M_wa       (M_wa),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
`ifdef STALL_CNT_EN
        .md_done    (md_done),
        .stall_count(stall_count)
`else
        .md_done    (md_done)
`endif
    );

    function automatic logic m_busy();
        return (md_left > 0) || E_md_start;
    endfunction

    function automatic logic m_done();
        return md_left == 1;
    endfunction

    function automatic logic m_opnd(input logic [4:0] r,
                                    input logic [1:0] tu);
        int t;
        t = int'(tu);
        if (r == 5'd0) return 1'b0;
        if (r == E_wa && t < int'(E_tnew)) return 1'b1;
        if (r == M_wa && t < int'(M_tnew)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        return m_opnd(D_rs, D_tuse_rs) || m_opnd(D_rt, D_tuse_rt) ||
               (D_is_md && m_busy());
    endfunction

    // Advance one clock: update the model from the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            md_left = 0;
            m_stall_cnt = 32'd0;
        end else begin
            if (m_stall()) m_stall_cnt = m_stall_cnt + 32'd1;
            if (md_left > 0) md_left = md_left - 1;
            else if (E_md_start) md_left = (E_md_div ? DIV_N : MULT_N) - 1;
        end
        #1;
    endtask

    task automatic quiet();
        D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3;
        D_is_md = 0; E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
        E_md_start = 0; E_md_div = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if ({md_busy, md_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_md got=%b exp=00", {md_busy, md_done});
        end
        vectors++;
        if ({stall_F, stall_D, flush_E} !== 3'b000) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=000",
                     {stall_F, stall_D, flush_E});
        end
        reset = 0;
        tick();
    endtask

    task automatic test_load_use();
        quiet();
        E_wa = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 0;
        @(negedge clk);
        vectors++;
        if ({stall_F, stall_D, flush_E} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_E got=%b exp=111",
                     {stall_F, stall_D, flush_E});
        end
        tick();
        E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
        @(negedge clk);
        vectors++;
        if ({stall_F, stall_D, flush_E} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_M got=%b exp=111",
                     {stall_F, stall_D, flush_E});
        end
        tick();
        M_tnew = 0;
        @(negedge clk);
        vectors++;
        if ({stall_F, stall_D, flush_E} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_fwd got=%b exp=000",
                     {stall_F, stall_D, flush_E});
        end
        tick();
        quiet();
    endtask

    task automatic test_zero_and_nouse();
        quiet();
        D_rs = 0; D_tuse_rs = 0; E_wa = 0; E_tnew = 2;
        @(negedge clk);
        vectors++;
        if (stall_F !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg got=%b exp=0", stall_F);
        end
        tick();
        quiet();
        D_rt = 5; D_tuse_rt = 3; E_wa = 5; E_tnew = 2;
        @(negedge clk);
        vectors++;
        if (stall_D !== 1'b0) begin
            errors++;
            $display("FAIL no_use got=%b exp=0", stall_D);
        end
        D_tuse_rt = 1;
        @(negedge clk);
        vectors++;
        if (flush_E !== 1'b1) begin
            errors++;
            $display("FAIL rt_use got=%b exp=1", flush_E);
        end
        tick();
        quiet();
    endtask

    task automatic test_mult();
        quiet();
        D_is_md = 1;
        for (int c = 0; c <= 5; c++) begin
            E_md_start = (c == 0);
            E_md_div = 0;
            @(negedge clk);
            vectors++;
            if ({md_busy, md_done, stall_F} !==
                {c <= 4, c == 4, c <= 4}) begin
                errors++;
                $display("FAIL mult_c%0d got=%b exp=%b", c,
                         {md_busy, md_done, stall_F},
                         {c <= 4, c == 4, c <= 4});
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_back_to_back();
        logic eb, ed;
        quiet();
        for (int c = 0; c <= 16; c++) begin
            E_md_start = (c == 0) || (c == 10);
            E_md_div = (c == 0);
            eb = (c <= 14);
            ed = (c == 9) || (c == 14);
            @(negedge clk);
            vectors++;
            if ({md_busy, md_done} !== {eb, ed}) begin
                errors++;
                $display("FAIL b2b_c%0d got=%b exp=%b", c,
                         {md_busy, md_done}, {eb, ed});
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_reset_mid_div();
        quiet();
        for (int c = 0; c <= 12; c++) begin
            E_md_start = (c == 0);
            E_md_div = 1;
            reset = (c == 4);
            @(negedge clk);
            vectors++;
            if ({md_busy, md_done} !== {c <= 4, 1'b0}) begin
                errors++;
                $display("FAIL rst_div_c%0d got=%b exp=%b", c,
                         {md_busy, md_done}, {c <= 4, 1'b0});
            end
            tick();
        end
        reset = 0;
        quiet();
    endtask

    task automatic test_start_with_reset();
        quiet();
        E_md_start = 1;
        reset = 1;
        tick();
        E_md_start = 0;
        reset = 0;
        @(negedge clk);
        vectors++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_rst got=%b exp=0", md_busy);
        end
        tick();
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_count();
        do_reset();
        E_wa = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 0;
        for (int i = 0; i < 3; i++) tick();
        quiet();
        D_is_md = 1;
        for (int c = 0; c < 8; c++) begin
            E_md_start = (c == 0);
            tick();
        end
        quiet();
        @(negedge clk);
        vectors++;
        if (stall_count !== 32'd8) begin
            errors++;
            $display("FAIL stall_cnt got=%0d exp=8", stall_count);
        end
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        vectors++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_rst got=%0d exp=0", stall_count);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            D_rs = 5'($urandom_range(0, 3));
            D_rt = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom_range(0, 3));
            D_tuse_rt = 2'($urandom_range(0, 3));
            E_wa = 5'($urandom_range(0, 3));
            M_wa = 5'($urandom_range(0, 3));
            E_tnew = 2'($urandom_range(0, 3));
            M_tnew = 2'($urandom_range(0, 3));
            D_is_md = ($urandom_range(0, 2) == 0);
            E_md_start = ($urandom_range(0, 5) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            got = {stall_F, stall_D, flush_E, md_busy, md_done};
            exp = {m_stall(), m_stall(), m_stall(), m_busy(), m_done()};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_%0d got=%b exp=%b", i, got, exp);
            end
`ifdef STALL_CNT_EN
            vectors++;
            if (stall_count !== m_stall_cnt) begin
                errors++;
                $display("FAIL rand_cnt_%0d got=%0d exp=%0d", i,
                         stall_count, m_stall_cnt);
            end
`endif
            tick();
        end
        reset = 0;
        quiet();
    endtask

    initial begin
        reset = 1;
        quiet();
        test_reset();
        test_load_use();
        test_zero_and_nouse();
        test_mult();
        test_back_to_back();
        test_reset_mid_div();
        test_start_with_reset();
`ifdef STALL_CNT_EN
        test_stall_count();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
